// File: rtl/c3lib_cdc_req_arb.sv
// Round-robin front end for one toggle-handshake crossing channel: grant registers payload, toggle launches a cycle later.
// Done pulses SYNC_STAGES+1 edges after the ack toggle arrives; requesters hold req_vld until granted, errors stick until clr_err.
module c3lib_cdc_req_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DWIDTH      = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DWIDTH-1:0]         cdc_data_out,
  output logic                      cdc_req_tgl,
  input  logic                      cdc_ack_tgl,
  output logic                      busy,
  output logic                      timeout_err,
  input  logic                      clr_err
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, ERR} state_t;

  state_t                 state, state_d;
  logic [PW-1:0]          ptr, ptr_d, owner, owner_d, win, idx;
  logic [TW-1:0]          timer, timer_d;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s, any_req, tgl_d, err_d;
  logic [DWIDTH-1:0]      data_d;
  logic [NUM_REQ-1:0]     gnt_d, done_d;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // First requester at or after ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!any_req && req_vld[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    timer_d = timer;
    tgl_d   = cdc_req_tgl;
    data_d  = cdc_data_out;
    err_d   = timeout_err;
    gnt_d   = '0;
    done_d  = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_d = win;
          data_d  = req_data[win*DWIDTH +: DWIDTH];
          gnt_d   = NUM_REQ'(1) << win;
          ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + PW'(1);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        tgl_d   = ~cdc_req_tgl;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (timer != '1) timer_d = timer + TW'(1);
        // An ack seen on the timeout cycle still completes the transfer.
        if (ack_s == cdc_req_tgl) begin
          done_d  = NUM_REQ'(1) << owner;
          state_d = IDLE;
        end else if (TIMEOUT_CYC != 0 && timer == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        if (clr_err) begin
          tgl_d   = ack_s;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      timer        <= '0;
      ack_sync     <= '0;
      cdc_req_tgl  <= 1'b0;
      cdc_data_out <= '0;
      req_gnt      <= '0;
      req_done     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      ptr          <= ptr_d;
      owner        <= owner_d;
      timer        <= timer_d;
      ack_sync     <= {ack_sync[SYNC_STAGES-2:0], cdc_ack_tgl};
      cdc_req_tgl  <= tgl_d;
      cdc_data_out <= data_d;
      req_gnt      <= gnt_d;
      req_done     <= done_d;
      busy         <= (state_d != IDLE);
      timeout_err  <= err_d;
    end
  end
endmodule

// File: tb/tb_c3lib_cdc_req_arb.sv
// Randomized bench for c3lib_cdc_req_arb with a cycle-level behavioural model and a destination emulator.
module tb_c3lib_cdc_req_arb;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;
  localparam int SY = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_vld = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_gnt, req_done;
  logic [DW-1:0] cdc_data_out;
  logic          cdc_req_tgl;
  logic          cdc_ack_tgl = 1'b0;
  logic          busy, timeout_err;
  logic          clr_err = 1'b0;

  c3lib_cdc_req_arb #(.NUM_REQ(NR), .DWIDTH(DW), .TIMEOUT_CYC(TO), .SYNC_STAGES(SY)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data),
    .req_gnt(req_gnt), .req_done(req_done), .cdc_data_out(cdc_data_out),
    .cdc_req_tgl(cdc_req_tgl), .cdc_ack_tgl(cdc_ack_tgl), .busy(busy),
    .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event not seen within its cycle budget (cycle %0d)", nm, cyc);
  endtask

  // Destination emulator: echoes each request toggle back after ack_dly cycles.
  bit ack_en = 1'b1;
  int ack_dly = 2;
  bit seen = 1'b0;
  bit pend = 1'b0;
  int cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      cdc_ack_tgl = 1'b0;
      seen = 1'b0;
      pend = 1'b0;
    end else begin
      if (cdc_req_tgl != seen) begin
        seen = cdc_req_tgl;
        pend = ack_en;
        cnt  = ack_dly;
      end
      if (pend) begin
        if (cnt == 0) begin
          cdc_ack_tgl = seen;
          pend = 1'b0;
        end else cnt--;
      end
    end
  end

  // Behavioural model: phase 0 idle, 1 launch, 2 waiting for ack, 3 error.
  int m_ph = 0, m_ptr = 0, m_owner = 0, m_wait = 0;
  bit m_tgl = 0, m_err = 0;
  bit [DW-1:0] m_data = '0;
  bit [NR-1:0] m_gnt = '0, m_done = '0;
  bit ack_q[$];
  always @(posedge clk) begin
    bit acks;
    int w;
    cyc++;
    if (!rst_n) begin
      m_ph = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
      m_tgl = 0; m_err = 0; m_data = '0; m_gnt = '0; m_done = '0;
      ack_q = {};
      for (int i = 0; i < SY; i++) ack_q.push_back(1'b0);
    end else begin
      // ack as seen by the source is the input sampled SY edges earlier
      acks = ack_q[0];
      void'(ack_q.pop_front());
      ack_q.push_back(cdc_ack_tgl);
      m_gnt = '0;
      m_done = '0;
      if (m_ph == 0) begin
        w = -1;
        for (int k = 0; k < NR; k++)
          if (w < 0 && req_vld[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        if (w >= 0) begin
          m_owner = w;
          m_data = req_data[w*DW +: DW];
          m_gnt[w] = 1'b1;
          m_ptr = (w + 1) % NR;
          m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_tgl = ~m_tgl;
        m_wait = 0;
        m_ph = 2;
      end else if (m_ph == 2) begin
        if (acks == m_tgl) begin
          m_done[m_owner] = 1'b1;
          m_ph = 0;
        end else if (m_wait == TO - 1) begin
          m_err = 1'b1;
          m_ph = 3;
        end
        m_wait++;
      end else if (clr_err) begin
        m_tgl = acks;
        m_err = 1'b0;
        m_ph = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("gnt", 32'(req_gnt), 32'(m_gnt));
      chk("done", 32'(req_done), 32'(m_done));
      chk("data", 32'(cdc_data_out), 32'(m_data));
      chk("tgl", 32'(cdc_req_tgl), 32'(m_tgl));
      chk("busy", 32'(busy), 32'(m_ph != 0));
      chk("err", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input string nm, input int lim, output int idx);
    idx = -1;
    for (int i = 0; i < lim && idx < 0; i++) begin
      step();
      for (int k = 0; k < NR; k++) if (req_gnt[k]) idx = k;
    end
    if (idx < 0) bound_expired(nm);
  endtask

  task automatic wait_done(input string nm, input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim && c < 0; i++) begin
      step();
      if (req_done != '0) c = cyc;
    end
    if (c < 0) bound_expired(nm);
  endtask

  task automatic wait_err(input string nm, input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim && c < 0; i++) begin
      step();
      if (timeout_err) c = cyc;
    end
    if (c < 0) bound_expired(nm);
  endtask

  task automatic wait_idle(input string nm, input int lim);
    bit ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      step();
      if (!busy) ok = 1'b1;
    end
    if (!ok) bound_expired(nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, c, l;
    int exp_order[5];
    logic [DW-1:0] pay[NR];
    exp_order = '{0, 1, 2, 3, 0};
    pay = '{8'h10, 8'h21, 8'h32, 8'h43};

    step();
    step();
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_gnt", 32'(req_gnt), 32'h0);
    chk("rst_tgl", 32'(cdc_req_tgl), 32'h0);
    chk("rst_data", 32'(cdc_data_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Round-robin with all four requesting
    ack_en = 1'b1; ack_dly = 2;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pay[i];
    req_vld = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_gnt("rr_wait", 40, g);
      chk("rr_order", 32'(g), 32'(exp_order[n]));
      chk("rr_payload", 32'(cdc_data_out), 32'(pay[exp_order[n]]));
    end
    req_vld = '0;
    wait_idle("rr_idle", 40);

    // Wrap and skip: grant 2 leaves ptr at 3, then 4'b0101 grants 0 then 2
    req_vld = 4'b0100;
    wait_gnt("wrap_a", 10, g);
    chk("wrap_first", 32'(req_gnt), 32'h4);
    req_vld = '0;
    wait_idle("wrap_idle_a", 40);
    req_vld = 4'b0101;
    wait_gnt("wrap_b", 10, g);
    chk("wrap_gnt0", 32'(req_gnt), 32'h1);
    req_vld = 4'b0100;
    wait_gnt("wrap_c", 40, g);
    chk("wrap_gnt2", 32'(req_gnt), 32'h4);
    req_vld = '0;
    wait_idle("wrap_idle_b", 40);

    // Single request, ack returned 10 cycles after the toggle
    ack_dly = 10;
    req_data[15:8] = 8'hA5;
    req_vld = 4'b0010;
    wait_gnt("single_wait", 10, g);
    chk("single_gnt", 32'(req_gnt), 32'h2);
    chk("single_data", 32'(cdc_data_out), 32'hA5);
    l = cdc_req_tgl;
    req_vld = '0;
    step();
    chk("single_tgl_flip", 32'(cdc_req_tgl), 32'(!l));
    l = cyc;
    wait_done("single_done", 40, c);
    chk("single_done_vec", 32'(req_done), 32'h2);
    chk("single_done_lat", 32'(c - l), 32'd13);
    chk("single_busy_low", 32'(busy), 32'h0);
    chk("single_data_hold", 32'(cdc_data_out), 32'hA5);

    // Timeout with ack never returned
    ack_en = 1'b0;
    req_vld = 4'b0001;
    wait_gnt("to_wait", 10, g);
    req_vld = '0;
    step();
    l = cyc;
    wait_err("to_err", 40, c);
    chk("to_err_lat", 32'(c - l), 32'd16);
    chk("to_busy", 32'(busy), 32'h1);
    req_vld = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("to_no_grant", 32'(req_gnt), 32'h0);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    ack_en = 1'b1;
    ack_dly = 3;
    chk("to_clr_err", 32'(timeout_err), 32'h0);
    chk("to_realign", 32'(cdc_req_tgl), 32'(cdc_ack_tgl));
    wait_gnt("to_regrant", 10, g);
    chk("to_regrant_vec", 32'(req_gnt), 32'h2);
    req_vld = '0;
    wait_idle("to_idle", 40);

    // Ack lands on the timeout cycle: completion wins
    ack_dly = TO - SY - 1;
    req_vld = 4'b1000;
    wait_gnt("tie_wait", 10, g);
    req_vld = '0;
    step();
    l = cyc;
    wait_done("tie_done", 40, c);
    chk("tie_done_lat", 32'(c - l), 32'd16);
    chk("tie_no_err", 32'(timeout_err), 32'h0);

    // Ack one cycle too late: error, late ack ignored
    ack_dly = TO - SY;
    req_vld = 4'b0001;
    wait_gnt("late_wait", 10, g);
    req_vld = '0;
    step();
    l = cyc;
    wait_err("late_err", 40, c);
    chk("late_err_lat", 32'(c - l), 32'd16);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("late_no_done", 32'(req_done), 32'h0);
      chk("late_busy", 32'(busy), 32'h1);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("late_clr", 32'(timeout_err), 32'h0);

    // Reset mid-transfer
    ack_en = 1'b0;
    req_vld = 4'b0010;
    wait_gnt("rstw_wait", 10, g);
    req_vld = '0;
    repeat (4) step();
    do_reset();
    chk("rstw_gnt", 32'(req_gnt), 32'h0);
    chk("rstw_done", 32'(req_done), 32'h0);
    chk("rstw_tgl", 32'(cdc_req_tgl), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_err", 32'(timeout_err), 32'h0);
    chk("rstw_data", 32'(cdc_data_out), 32'h0);
    chk("rstw_model_ptr", 32'(m_ptr), 32'h0);
    ack_en = 1'b1;
    ack_dly = 1;
    req_vld = 4'b1000;
    wait_gnt("rstw_regrant", 10, g);
    chk("rstw_gnt3", 32'(req_gnt), 32'h8);
    req_vld = '0;
    step();
    chk("rstw_tgl_rise", 32'(cdc_req_tgl), 32'h1);
    wait_idle("rstw_idle", 40);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      req_vld = req_vld & ~req_gnt;
      if ($urandom_range(3) == 0) req_vld = req_vld | 4'($urandom);
      req_data = $urandom;
      ack_dly = $urandom_range(20);
      ack_en = ($urandom_range(9) != 0);
      clr_err = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(299) != 0);
      step();
    end
    rst_n = 1'b1;
    clr_err = 1'b0;
    req_vld = '0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
